// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first, valid/ready handshake.
// Define ADDSUB_SERIAL_FLAGS_EN to build the C/V/Z flag logic; otherwise the flags are tied to 0.
module addsub_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             fn,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             C,
   output logic             V,
   output logic             Z
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             cy;
   logic [WIDTH-1:0] a_r, b_r, s_r, s_nxt;
   logic [DIGIT:0]   dsum;
   logic             last;

   // Subtraction is A + ~B + 1: B is inverted on load and the carry seeded with fn.
   assign dsum = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy};
   assign last = (cnt == CW'(N-1));

   always_comb begin
      s_nxt = s_r;
      s_nxt[int'(cnt)*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         cy    <= 1'b0;
         a_r   <= '0;
         b_r   <= '0;
         s_r   <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_r   <= A;
               b_r   <= B ^ {WIDTH{fn}};
               cy    <= fn;
               cnt   <= '0;
               state <= RUN;
            end
            RUN: begin
               s_r <= s_nxt;
               cy  <= dsum[DIGIT];
               a_r <= a_r >> DIGIT;
               b_r <= b_r >> DIGIT;
               cnt <= cnt + CW'(1);
               if (last) state <= DONE;
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign S         = s_r;

`ifdef ADDSUB_SERIAL_FLAGS_EN
   logic c_r, v_r, z_r;

   // Carry into the MSB is recovered from the MSB sum bit: s ^ a ^ b.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         c_r <= 1'b0;
         v_r <= 1'b0;
         z_r <= 1'b0;
      end else if (state == RUN && last) begin
         c_r <= dsum[DIGIT];
         v_r <= (a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ dsum[DIGIT-1]) ^ dsum[DIGIT];
         z_r <= (s_nxt == '0);
      end
   end

   assign C = c_r;
   assign V = v_r;
   assign Z = z_r;
`else
   assign C = 1'b0;
   assign V = 1'b0;
   assign Z = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: accepted operations are modelled with plain arithmetic
// and queued; a monitor compares every result the DUT presents.
module tb_addsub_serial;
   localparam int WIDTH = 16;
   localparam int DIGIT = 4;
   localparam int N     = WIDTH / DIGIT;

   logic             Clk = 1'b0, Reset_n = 1'b0;
   logic             in_valid = 1'b0, in_ready, fn = 1'b0;
   logic             out_valid, out_ready = 1'b1;
   logic [WIDTH-1:0] A = '0, B = '0, S;
   logic             C, V, Z;

   typedef struct {
      logic [WIDTH-1:0] s;
      logic             c, v, z;
      int               acc;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0, errors = 0, cyc = 0, last_acc = 0;
   bit   rand_ordy = 0;
   logic ov_d = 1'b0;

   addsub_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .fn(fn), .out_valid(out_valid), .out_ready(out_ready),
      .S(S), .C(C), .V(V), .Z(Z)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic f, input int acc);
      exp_t   e;
      longint ua, ub, ru, sa, sb, rs;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ru = f ? ua - ub : ua + ub;
      rs = f ? sa - sb : sa + sb;
      e.s   = ru[WIDTH-1:0];
      e.acc = acc;
`ifdef ADDSUB_SERIAL_FLAGS_EN
      e.c = f ? (ua >= ub) : (ru >= (64'sd1 <<< WIDTH));
      e.v = (rs > ((64'sd1 <<< (WIDTH-1)) - 1)) || (rs < -(64'sd1 <<< (WIDTH-1)));
      e.z = (e.s == '0);
`else
      e.c = 1'b0;
      e.v = 1'b0;
      e.z = 1'b0;
`endif
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: record acceptances, compare presented results, flush on reset.
   always @(negedge Clk) begin
      exp_t e;
      if (!Reset_n) begin
         sbq.delete();
         ov_d = 1'b0;
      end else begin
         if (in_valid && in_ready) sbq.push_back(model(A, B, fn, cyc + 1));
         if (out_valid) begin
            chk("in_ready_low_in_done", in_ready, 0);
            if (sbq.size() == 0) chk("spurious_out_valid", out_valid, 0);
            else begin
               e = sbq[0];
               if (!ov_d) chk("latency", cyc - e.acc, N);
               chk("S", S, e.s);
               chk("C", C, e.c);
               chk("V", V, e.v);
               chk("Z", Z, e.z);
               if (out_ready) void'(sbq.pop_front());
            end
         end
         ov_d = out_valid;
      end
   end

   always @(posedge Clk) begin
      if (rand_ordy) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Present an operation and hold it until an edge accepts it; returns at posedge+1.
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic f);
      int n;
      A = a; B = b; fn = f; in_valid = 1'b1;
      n = 0;
      @(negedge Clk);
      while (!in_ready && n < 200) begin
         @(negedge Clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", in_ready, 1);
      @(posedge Clk); #1;
      in_valid = 1'b0;
      last_acc = cyc;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sbq.size() != 0 || !in_ready) && n < 300) begin
         @(posedge Clk); #1;
         n++;
      end
      if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_S", S, 0);
      chk("rst_C", C, 0);
      chk("rst_V", V, 0);
      chk("rst_Z", Z, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
   endtask

   initial begin
      int a1, rel;
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, rel;
      repeat (2) @(posedge Clk);
      #1;
      chk_reset_outputs();
      Reset_n = 1'b1;

      // Overflow into the sign bit, then equal and borrowing subtracts.
      send(16'h7FFF, 16'h0001, 1'b0);
      wait_idle();
      send(16'h0005, 16'h0005, 1'b1);
      wait_idle();
      send(16'h0003, 16'h0005, 1'b1);
      wait_idle();

      // Result held in DONE while the consumer stalls; new requests ignored.
      out_ready = 1'b0;
      send(16'hFFFF, 16'h0001, 1'b0);
      repeat (N + 10) begin
         in_valid = 1'b1;
         A = 16'($urandom); B = 16'($urandom); fn = 1'($urandom);
         @(posedge Clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle();

      // Back-to-back: second request is waiting while the first one runs.
      send(16'h1234, 16'h1111, 1'b0);
      a1 = last_acc;
      send(16'h1234, 16'h1111, 1'b1);
      chk("b2b_period", last_acc - a1, N + 2);
      wait_idle();

      // Reset during the second RUN cycle abandons the operation.
      send(16'h4321, 16'h1111, 1'b0);
      @(posedge Clk); #1;
      Reset_n = 1'b0;
      #1;
      chk_reset_outputs();
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      repeat (N + 4) begin
         @(negedge Clk);
         chk("no_result_after_reset", out_valid, 0);
      end

      // Acceptance on the first edge after reset release.
      @(posedge Clk); #1;
      Reset_n = 1'b0;
      #2;
      Reset_n = 1'b1;
      rel = cyc;
      send(16'h00FF, 16'h0F01, 1'b0);
      chk("accept_after_reset", last_acc, rel + 1);
      wait_idle();

      // Randomised traffic with stalling consumer and ignored mid-run requests.
      rand_ordy = 1;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge Clk); #1;
         end
         send(16'($urandom), 16'($urandom), 1'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            repeat (N - 1) begin
               in_valid = 1'b1;
               A = 16'($urandom); B = 16'($urandom); fn = 1'($urandom);
               @(posedge Clk); #1;
            end
            in_valid = 1'b0;
         end
      end
      rand_ordy = 0;
      @(posedge Clk); #2;
      out_ready = 1'b1;
      wait_idle();
      chk("scoreboard_empty", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits (>= 2).
REQ-002 SHALL have parameter DIGIT, default 4: bits processed per clock; WIDTH mod DIGIT SHALL be 0; N = WIDTH/DIGIT.
REQ-003 SHALL have port Clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operands A, B, fn presented.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port A  input  WIDTH  first operand.
REQ-008 SHALL have port B  input  WIDTH  second operand.
REQ-009 SHALL have port fn  input  1  0 = A+B, 1 = A-B.
REQ-010 SHALL have port out_valid  output  1  S and flags hold a completed result.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port S  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 SHALL have ports C, V, Z  output  1 each  carry-out, signed overflow, zero flags.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 IDLE: on edge with in_valid=1, SHALL register A, B XOR {WIDTH{fn}}, and fn, load carry register with fn, clear digit counter, go RUN; in_valid=0 stays IDLE.
REQ-016 RUN: each edge SHALL add the low DIGIT bits of the A and B registers plus carry register, place the DIGIT-bit sum in the next digit of S (LSB digit first), update carry, shift A/B right by DIGIT.
REQ-017 RUN SHALL last exactly N edges; the edge processing digit N-1 SHALL move to DONE, so out_valid rises N cycles after the accepting edge.
REQ-018 DONE: S, C, V, Z SHALL be held stable; on edge with out_ready=1 go IDLE; out_ready=0 stays DONE indefinitely.
REQ-019 in_valid while in RUN or DONE SHALL be ignored (no acceptance, no operand change).
REQ-020 out_ready while not DONE SHALL have no effect.
REQ-021 C SHALL be carry out of bit WIDTH-1 (for subtract, C=1 means no borrow).
REQ-022 V SHALL be carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-023 Z SHALL be 1 iff S == 0.
REQ-024 S, C, V, Z values while out_valid=0 are don't-care for consumers but SHALL not be X after reset.

Reset
REQ-025 Reset_n=0 SHALL asynchronously force state IDLE, counter 0, carry 0, S=0, C=V=Z=0, out_valid=0, in_ready=1.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abandon the operation; no result is delivered after release.
REQ-027 After Reset_n rises, first acceptance SHALL be possible on the next rising edge with in_valid=1.

Configuration
REQ-028 Macro ADDSUB_SERIAL_FLAGS_EN defined: C, V, Z computed per REQ-021..023, registered at DONE entry.
REQ-029 Macro undefined: C, V, Z SHALL be constant 0 and no flag logic synthesised; S and handshake unchanged.

Verification (WIDTH=16, DIGIT=4, flags enabled unless noted)
REQ-030 A=0x7FFF, B=0x0001, fn=0 -> out_valid 4 cycles after accept, S=0x8000, C=0, V=1, Z=0.
REQ-031 A=0x0005, B=0x0005, fn=1 -> S=0x0000, C=1, V=0, Z=1; A=0x0003, B=0x0005, fn=1 -> S=0xFFFE, C=0, V=0, Z=0.
REQ-032 A=0xFFFF, B=0x0001, fn=0, out_ready held 0 for 10 cycles -> S=0x0000, C=1, Z=1 held stable, in_ready=0 throughout; new in_valid ignored.
REQ-033 Reset_n pulsed low during 2nd RUN cycle -> immediate IDLE, out_valid=0, all outputs 0; no out_valid after release.
REQ-034 Back-to-back: out_ready=1, in_valid=1 continuously with 0x1234+0x1111 then 0x1234-0x1111 -> S=0x2345 then S=0x0123, one result per 6 cycles (1 accept + 4 RUN + 1 DONE), no operand corruption.
REQ-035 Macro undefined, A=0x7FFF+0x0001 -> S=0x8000, C=V=Z=0.
